// File: rtl/arm_regfile_pkg.sv
// arm_regfile_pkg: shared register numbers, default PC read offset and write-port bundle type
package arm_regfile_pkg;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [31:0] PC_READ_OFFSET_DEF = 32'd8;
  typedef struct packed {
    logic        we;
    logic [3:0]  num;
    logic [31:0] data;
  } wr_port_t;
endpackage

// File: rtl/arm_regfile_rdport.sv
// arm_regfile_rdport: one read port, priority r15(pc_in+offset) > WB bypass > base bypass > stored
module arm_regfile_rdport
  import arm_regfile_pkg::*;
#(
  parameter logic [31:0] PC_READ_OFFSET = PC_READ_OFFSET_DEF
) (
  input  logic [3:0]  num,
  input  logic [31:0] stored,
  input  logic [31:0] pc_in,
  input  wr_port_t    wb,
  input  wr_port_t    base,
  output logic [31:0] data
);
  always_comb
    data = num == REG_PC ? pc_in + PC_READ_OFFSET :
           (wb.we && wb.num == num) ? wb.data :
           (base.we && base.num == num) ? base.data : stored;
endmodule

// File: rtl/arm_regfile.sv
// arm_regfile: r0-r14 storage, three bypassed combinational reads, WB/base writes, r15 writes become a registered pc_load pulse
module arm_regfile
  import arm_regfile_pkg::*;
#(
  parameter logic [31:0] PC_READ_OFFSET = PC_READ_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rn_num,
  input  logic [3:0]  rm_num,
  input  logic [3:0]  rs_num,
  output logic [31:0] rn_data,
  output logic [31:0] rm_data,
  output logic [31:0] rs_data,
  input  logic [31:0] pc_in,
  input  logic [31:0] WB_data,
  input  logic        WB_rd_we,
  input  logic [3:0]  WB_des_reg_num,
  input  logic        base_we,
  input  logic [3:0]  base_num,
  input  logic [31:0] base_data,
  output logic        pc_load,
  output logic [31:0] pc_load_addr
);
  logic [31:0] regs [0:14];
  logic [31:0] rn_st, rm_st, rs_st;
  logic wb_pc, base_pc;
  wr_port_t wb, base;
  always_comb begin
    wb = '{WB_rd_we, WB_des_reg_num, WB_data};
    base = '{base_we, base_num, base_data};
    wb_pc = WB_rd_we && WB_des_reg_num == REG_PC;
    base_pc = base_we && base_num == REG_PC;
    rn_st = rn_num == REG_PC ? '0 : regs[rn_num];
    rm_st = rm_num == REG_PC ? '0 : regs[rm_num];
    rs_st = rs_num == REG_PC ? '0 : regs[rs_num];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
      pc_load <= 1'b0;
      pc_load_addr <= '0;
    end else begin
      for (int i = 0; i < 15; i++)
        regs[i] <= (WB_rd_we && WB_des_reg_num == 4'(i)) ? WB_data :
                   (base_we && base_num == 4'(i)) ? base_data : regs[i];
      pc_load <= wb_pc || base_pc;
      pc_load_addr <= wb_pc ? WB_data : base_pc ? base_data : pc_load_addr;
    end
  end
  arm_regfile_rdport #(.PC_READ_OFFSET(PC_READ_OFFSET)) u_rn (
    .num(rn_num), .stored(rn_st), .pc_in(pc_in), .wb(wb), .base(base), .data(rn_data));
  arm_regfile_rdport #(.PC_READ_OFFSET(PC_READ_OFFSET)) u_rm (
    .num(rm_num), .stored(rm_st), .pc_in(pc_in), .wb(wb), .base(base), .data(rm_data));
  arm_regfile_rdport #(.PC_READ_OFFSET(PC_READ_OFFSET)) u_rs (
    .num(rs_num), .stored(rs_st), .pc_in(pc_in), .wb(wb), .base(base), .data(rs_data));
endmodule

// File: tb/tb_arm_regfile.sv
// tb_arm_regfile: table-driven vectors with a scoreboard queue for the registered pc_load outputs
module tb_arm_regfile;
  typedef struct packed {
    logic        rst;
    logic [3:0]  rn, rm, rs;
    logic [31:0] pc;
    logic        wwe;
    logic [3:0]  wnum;
    logic [31:0] wdat;
    logic        bwe;
    logic [3:0]  bnum;
    logic [31:0] bdat;
    logic [31:0] ern, erm, ers;
    logic        epl;
    logic [31:0] epa;
  } vec_t;
  typedef struct packed {
    logic        pl;
    logic [31:0] pa;
  } sb_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] rn_num = '0, rm_num = '0, rs_num = '0, WB_des_reg_num = '0, base_num = '0;
  logic [31:0] rn_data, rm_data, rs_data, pc_load_addr;
  logic [31:0] pc_in = '0, WB_data = '0, base_data = '0;
  logic WB_rd_we = 1'b0, base_we = 1'b0, pc_load;
  int total = 0, bad = 0;
  vec_t vecs [14];
  sb_t sb [$];
  always #5 clk = ~clk;
  arm_regfile dut (
    .clk(clk), .rst(rst),
    .rn_num(rn_num), .rm_num(rm_num), .rs_num(rs_num),
    .rn_data(rn_data), .rm_data(rm_data), .rs_data(rs_data),
    .pc_in(pc_in), .WB_data(WB_data), .WB_rd_we(WB_rd_we), .WB_des_reg_num(WB_des_reg_num),
    .base_we(base_we), .base_num(base_num), .base_data(base_data),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input int idx);
    sb_t e;
    rst = v.rst; rn_num = v.rn; rm_num = v.rm; rs_num = v.rs; pc_in = v.pc;
    WB_rd_we = v.wwe; WB_des_reg_num = v.wnum; WB_data = v.wdat;
    base_we = v.bwe; base_num = v.bnum; base_data = v.bdat;
    #1;
    chk($sformatf("rn[%0d]", idx), rn_data, v.ern);
    chk($sformatf("rm[%0d]", idx), rm_data, v.erm);
    chk($sformatf("rs[%0d]", idx), rs_data, v.ers);
    sb.push_back('{v.epl, v.epa});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty[%0d]", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("pc_load[%0d]", idx), {31'd0, pc_load}, {31'd0, e.pl});
      if (e.pl) chk($sformatf("pc_load_addr[%0d]", idx), pc_load_addr, e.pa);
    end
    @(negedge clk);
  endtask
  initial begin
    //            rst   rn     rm     rs     pc            wwe   wnum   wdat          bwe   bnum   bdat          ern           erm           ers           epl   epa
    vecs[0]  = '{1'b0, 4'd4,  4'd15, 4'd3,  32'h100,      1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0,  32'h0,        32'h0,        32'h108,      32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'd3,  4'd3,  4'd3,  32'h100,      1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'd4,  4'd5,  4'd15, 32'hFFFFFFFC, 1'b1, 4'd5,  32'h1234,     1'b0, 4'd0,  32'h0,        32'h0,        32'h1234,     32'h4,        1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'd2,  4'd2,  4'd5,  32'h0,        1'b1, 4'd2,  32'hA,        1'b1, 4'd2,  32'hB,        32'hA,        32'hA,        32'h1234,     1'b0, 32'h0};
    vecs[4]  = '{1'b0, 4'd2,  4'd5,  4'd7,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd7,  32'h55,       32'hA,        32'h1234,     32'h55,       1'b0, 32'h0};
    vecs[5]  = '{1'b0, 4'd15, 4'd7,  4'd2,  32'h200,      1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 32'h2000,     32'h208,      32'h55,       32'hA,        1'b1, 32'h2000};
    vecs[6]  = '{1'b0, 4'd15, 4'd14, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        32'h8,        32'h0,        32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b0, 4'd15, 4'd1,  4'd3,  32'h10,       1'b1, 4'd15, 32'h3000,     1'b1, 4'd15, 32'h4000,     32'h18,       32'h0,        32'hDEADBEEF, 1'b1, 32'h3000};
    vecs[8]  = '{1'b0, 4'd3,  4'd2,  4'd5,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 32'h5000,     32'hDEADBEEF, 32'hA,        32'h1234,     1'b1, 32'h5000};
    vecs[9]  = '{1'b0, 4'd9,  4'd15, 4'd9,  32'h20,       1'b1, 4'd15, 32'h6000,     1'b1, 4'd9,  32'h99,       32'h99,       32'h28,       32'h99,       1'b1, 32'h6000};
    vecs[10] = '{1'b0, 4'd9,  4'd7,  4'd6,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        32'h99,       32'h55,       32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'd14, 4'd14, 4'd14, 32'h0,        1'b1, 4'd14, 32'hCAFE,     1'b1, 4'd14, 32'hBEEF,     32'hCAFE,     32'hCAFE,     32'hCAFE,     1'b0, 32'h0};
    vecs[12] = '{1'b0, 4'd1,  4'd6,  4'd14, 32'h0,        1'b1, 4'd1,  32'h11,       1'b1, 4'd6,  32'h66,       32'h11,       32'h66,       32'hCAFE,     1'b0, 32'h0};
    vecs[13] = '{1'b0, 4'd1,  4'd6,  4'd2,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        32'h11,       32'h66,       32'hA,        1'b0, 32'h0};
    @(negedge clk);
    @(negedge clk);
    chk("reset_pc_load", {31'd0, pc_load}, 32'd0);
    chk("reset_pc_load_addr", pc_load_addr, 32'h0);
    for (int i = 0; i < 14; i++) step(vecs[i], i);
    step('{1'b0, 4'd8, 4'd3, 4'd15, 32'h30, 1'b1, 4'd15, 32'h7000, 1'b0, 4'd0, 32'h0,
           32'h0, 32'hDEADBEEF, 32'h38, 1'b1, 32'h7000}, 100);
    step('{1'b1, 4'd8, 4'd15, 4'd1, 32'h40, 1'b1, 4'd8, 32'h88, 1'b1, 4'd4, 32'h44,
           32'h88, 32'h48, 32'h11, 1'b0, 32'h0}, 101);
    step('{1'b0, 4'd8, 4'd3, 4'd4, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
           32'h0, 32'h0, 32'h0, 1'b0, 32'h0}, 102);
    step('{1'b0, 4'd1, 4'd14, 4'd15, 32'h50, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
           32'h0, 32'h0, 32'h58, 1'b0, 32'h0}, 103);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
